// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Sequencer that programs a serial chain of static_dff configuration cells.
// Bitstream words arrive over a valid/ready port and are shifted MSB-first
// into the chain head, one bit per clock, with a registered shift enable.
// Optional feature: define CCFF_TAIL_CHECK_EN to add the cc_tail input and
// an end-of-run check that the first shifted bit reached the chain tail.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
`ifdef CCFF_TAIL_CHECK_EN
    input  logic              cc_tail,
`endif
    output logic              cc_head,
    output logic              cc_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_W_C    = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    state_t            state_r;
    logic [WORD_W-1:0] word_r;      // bits still waiting to be shifted, MSB next
    logic [CNT_W-1:0]  bit_cnt_r;   // bits shifted so far in this run
    logic [CNT_W-1:0]  rem_r;       // shift cycles left in the current word after this one
    logic [CNT_W-1:0]  remaining_s;
    logic [CNT_W-1:0]  n_s;         // bits to take from the word being accepted

`ifdef CCFF_TAIL_CHECK_EN
    logic              first_bit_r; // first bit shifted in the run
    logic              chk_pend_r;  // tail comparison due at the next edge
`endif

    // Number of bits to shift from the next word: a full word, or the tail of the chain
    always_comb begin
        remaining_s = CHAIN_LEN_C - bit_cnt_r;
        if (remaining_s < WORD_W_C) begin
            n_s = remaining_s;
        end else begin
            n_s = WORD_W_C;
        end
    end

    // Sequencer FSM with datapath and registered handshake/chain outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= S_IDLE;
            word_r    <= '0;
            bit_cnt_r <= '0;
            rem_r     <= '0;
            in_ready  <= 1'b0;
            cc_head   <= 1'b0;
            cc_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
            first_bit_r <= 1'b0;
            chk_pend_r  <= 1'b0;
`endif
        end else if (abort) begin
            // Abort beats start; err is deliberately left untouched
            state_r  <= S_IDLE;
            in_ready <= 1'b0;
            cc_head  <= 1'b0;
            cc_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
            chk_pend_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_r   <= S_LOAD;
                        bit_cnt_r <= '0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        // First bit goes out with cc_en on the very next cycle
                        state_r  <= S_SHIFT;
                        word_r   <= in_data << 1;
                        cc_head  <= in_data[WORD_W-1];
                        cc_en    <= 1'b1;
                        in_ready <= 1'b0;
                        rem_r    <= n_s - ONE_C;
`ifdef CCFF_TAIL_CHECK_EN
                        if (bit_cnt_r == '0) begin
                            first_bit_r <= in_data[WORD_W-1];
                        end else begin
                            first_bit_r <= first_bit_r;
                        end
`endif
                    end else begin
                        state_r <= S_LOAD;
                    end
                end
                S_SHIFT: begin
                    // The chain takes one bit at every edge of this state
                    bit_cnt_r <= bit_cnt_r + ONE_C;
                    if (rem_r == '0) begin
                        cc_en   <= 1'b0;
                        cc_head <= 1'b0;
                        if (bit_cnt_r == CHAIN_LEN_C - ONE_C) begin
                            state_r <= S_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
                            // First bit sits on the tail Q once this final shift lands
                            chk_pend_r <= (CHAIN_LEN > 1);
`endif
                        end else begin
                            state_r  <= S_LOAD;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        cc_head <= word_r[WORD_W-1];
                        word_r  <= word_r << 1;
                        rem_r   <= rem_r - ONE_C;
                    end
                end
                default: begin
                    state_r  <= S_IDLE;
                    in_ready <= 1'b0;
                    cc_head  <= 1'b0;
                    cc_en    <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
`ifdef CCFF_TAIL_CHECK_EN
            if (chk_pend_r) begin
                chk_pend_r <= 1'b0;
                if (cc_tail != first_bit_r) begin
                    err <= 1'b1;
                end else begin
                    err <= err;
                end
            end else begin
                chk_pend_r <= chk_pend_r;
            end
`endif
        end
    end

endmodule
